// File: rtl/fp_cmp_arbiter.sv
// ---------------------------------------------------------------------------
// fp_cmp_arbiter -- round-robin arbiter that lets NUM_REQ requesters share a
// single floating-point compare datapath.
//
// Contents (self-contained):
//   pkg_opengpu     DATA_WIDTH and the fpu_op_t operation encoding
//   fp_compare      combinational IEEE-754 single-precision compare
//   fp_cmp_arbiter  arbiter + one-entry result register
//
// fp_cmp_arbiter ports:
//   clk          in   clock, all state on the rising edge
//   rst          in   asynchronous active-high reset
//   req_valid    in   [NUM_REQ]             per-requester request valid
//   req_ready    out  [NUM_REQ]             per-requester accept (one-hot or zero)
//   req_op_a     in   [NUM_REQ*DATA_WIDTH]  operand A, slice i = requester i
//   req_op_b     in   [NUM_REQ*DATA_WIDTH]  operand B, slice i = requester i
//   req_fpu_op   in   fpu_op_t [NUM_REQ]    compare op per requester
//   resp_valid   out  result valid
//   resp_ready   in   consumer accept
//   resp_id      out  [$clog2(NUM_REQ)]     index of the requester owning the result
//   resp_result  out  [DATA_WIDTH]          compare result (0 or 1)
//   stall_count  out  [32]                  only with FP_CMP_ARB_STATS_EN defined:
//                                           saturating count of cycles where some
//                                           valid request was not accepted
//
// Build option: define FP_CMP_ARB_STATS_EN to add the stall_count port/counter.
// ---------------------------------------------------------------------------

package pkg_opengpu;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        FPU_ADD   = 4'd0,
        FPU_SUB   = 4'd1,
        FPU_MUL   = 4'd2,
        FPU_CMPEQ = 4'd3,
        FPU_CMPLT = 4'd4,
        FPU_CMPLE = 4'd5
    } fpu_op_t;
endpackage

// ---------------------------------------------------------------------------
// fp_compare -- combinational single-precision compare.
//   op_a, op_b  in   operands
//   fpu_op      in   FPU_CMPEQ / FPU_CMPLT / FPU_CMPLE; anything else yields 0
//   result      out  0 or 1; NaN on either side yields 0; +0 == -0
// ---------------------------------------------------------------------------
module fp_compare
    import pkg_opengpu::*;
(
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  fpu_op_t               fpu_op,
    output logic [DATA_WIDTH-1:0] result
);
    logic a_nan;
    logic b_nan;
    logic both_zero;
    logic eq;
    logic lt;

    always_comb begin
        a_nan     = (&op_a[30:23]) && (|op_a[22:0]);
        b_nan     = (&op_b[30:23]) && (|op_b[22:0]);
        both_zero = (op_a[30:0] == '0) && (op_b[30:0] == '0);
        eq        = both_zero || (op_a == op_b);

        // Sign-magnitude ordering: magnitudes compare directly as integers,
        // reversed when both operands are negative.
        if (op_a[31] != op_b[31]) begin
            lt = op_a[31] && !both_zero;
        end else if (!op_a[31]) begin
            lt = op_a[30:0] < op_b[30:0];
        end else begin
            lt = op_a[30:0] > op_b[30:0];
        end

        result = '0;
        if (!a_nan && !b_nan) begin
            case (fpu_op)
                FPU_CMPEQ: result[0] = eq;
                FPU_CMPLT: result[0] = lt;
                FPU_CMPLE: result[0] = lt || eq;
                default:   result[0] = 1'b0;
            endcase
        end
    end
endmodule

// ---------------------------------------------------------------------------
// fp_cmp_arbiter
// ---------------------------------------------------------------------------
module fp_cmp_arbiter
    import pkg_opengpu::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_b,
    input  fpu_op_t                       req_fpu_op [NUM_REQ],
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic [DATA_WIDTH-1:0]         resp_result
`ifdef FP_CMP_ARB_STATS_EN
    ,
    output logic [31:0]                   stall_count
`endif
);
    localparam int          IDW = $clog2(NUM_REQ);
    localparam int unsigned NR  = NUM_REQ;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    logic [0:0]            state;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        grant;
    logic [IDW-1:0]        sel;
    logic                  grant_vld;
    logic                  can_accept;
    logic                  accept;
    int unsigned           sum;
    logic [DATA_WIDTH-1:0] cmp_a;
    logic [DATA_WIDTH-1:0] cmp_b;
    fpu_op_t               cmp_op;
    logic [DATA_WIDTH-1:0] cmp_result;

    // Reset gates acceptance so req_ready stays low for as long as rst is high,
    // independent of the clock.
    assign can_accept = !rst && ((state == IDLE) || ((state == RESP) && resp_ready));
    assign accept     = can_accept && grant_vld;
    assign resp_valid = (state == RESP);

    // Round-robin: scan from rr_ptr+1 upward, wrapping at NUM_REQ.
    always_comb begin
        grant     = rr_ptr;
        grant_vld = 1'b0;
        sum       = 0;
        sel       = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            sum = 32'(rr_ptr) + k;
            if (sum >= NR) begin
                sum = sum - NR;
            end
            sel = IDW'(sum);
            if (!grant_vld && req_valid[sel]) begin
                grant_vld = 1'b1;
                grant     = sel;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Operand mux from the granted requester's slices.
    always_comb begin
        cmp_a  = '0;
        cmp_b  = '0;
        cmp_op = FPU_ADD;
        for (int unsigned i = 0; i < NR; i++) begin
            if (32'(grant) == i) begin
                cmp_a  = req_op_a[i*DATA_WIDTH +: DATA_WIDTH];
                cmp_b  = req_op_b[i*DATA_WIDTH +: DATA_WIDTH];
                cmp_op = req_fpu_op[i];
            end
        end
    end

    fp_compare u_fp_compare (
        .op_a   (cmp_a),
        .op_b   (cmp_b),
        .fpu_op (cmp_op),
        .result (cmp_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            resp_id     <= '0;
            resp_result <= '0;
            rr_ptr      <= IDW'(NUM_REQ - 1);
        end else if (accept) begin
            state       <= RESP;
            resp_id     <= grant;
            resp_result <= cmp_result;
            rr_ptr      <= grant;
        end else if ((state == RESP) && resp_ready) begin
            state <= IDLE;
        end
    end

`ifdef FP_CMP_ARB_STATS_EN
    logic stall_cycle;

    assign stall_cycle = |(req_valid & ~req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_cycle && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fp_cmp_arbiter.md
FP_CMP_ARBITER -- requirements
Module: fp_cmp_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of requesters sharing one compare datapath (range 2..8).
REQ-002 SHALL take DATA_WIDTH (32) and fpu_op_t from pkg_opengpu.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits, per-requester request valid.
REQ-006 SHALL have port req_ready, output, NUM_REQ bits, per-requester accept.
REQ-007 SHALL have port req_op_a, input, NUM_REQ*DATA_WIDTH bits, operand A; slice i is requester i.
REQ-008 SHALL have port req_op_b, input, NUM_REQ*DATA_WIDTH bits, operand B; slice i is requester i.
REQ-009 SHALL have port req_fpu_op, input, NUM_REQ x fpu_op_t, the compare op per requester.
REQ-010 SHALL have port resp_valid, output, 1 bit, result valid.
REQ-011 SHALL have port resp_ready, input, 1 bit, consumer accept.
REQ-012 SHALL have port resp_id, output, $clog2(NUM_REQ) bits, the index of the requester that owns the result.
REQ-013 SHALL have port resp_result, output, DATA_WIDTH bits, the compare result (0 or 1).

Function
REQ-014 SHALL instantiate exactly one fp_compare and drive it from the granted requester's slices.
REQ-015 SHALL use a two-state FSM with states IDLE (no result held) and RESP (result held).
REQ-016 SHALL define can_accept = (state==IDLE) || (state==RESP && resp_ready).
REQ-017 SHALL choose grant by round-robin: the first valid index after rr_ptr (modulo NUM_REQ); rr_ptr resets to NUM_REQ-1, so requester 0 has first priority.
REQ-018 SHALL assert req_ready[i] only when can_accept, req_valid[i] and i==grant; at most one bit is high per cycle.
REQ-019 SHALL, on accept, register the fp_compare output into resp_result, register grant into resp_id and rr_ptr, and set the state to RESP.
REQ-020 SHALL present resp_valid one cycle after accept, i.e. latency 1 cycle.
REQ-021 SHALL sustain throughput of 1 result per cycle while resp_ready is held high.
REQ-022 SHALL transition RESP to IDLE when resp_ready is high and no request is valid.
REQ-023 SHALL hold resp_valid, resp_id and resp_result stable while resp_valid && !resp_ready, with req_ready all zero.
REQ-024 SHALL return 0 for NaN operands and for an unsupported fpu_op; +0 and -0 compare equal.
REQ-025 SHALL not move rr_ptr when no accept occurs.

Reset
REQ-026 SHALL, while rst is high, set state=IDLE, resp_valid=0, resp_id=0, resp_result=0, rr_ptr=NUM_REQ-1 and req_ready=0, independent of clk.
REQ-027 SHALL discard an undelivered result when reset asserts mid-RESP; it is never presented afterward.

Configuration
REQ-028 SHALL provide macro FP_CMP_ARB_STATS_EN.
REQ-029 SHALL, when FP_CMP_ARB_STATS_EN is defined, add output stall_count, 32 bits, reset 0, incremented by 1 each cycle in which some req_valid bit is high without a matching req_ready, saturating at 0xFFFFFFFF.
REQ-030 SHALL, when FP_CMP_ARB_STATS_EN is undefined, have no stall_count port and no counter logic, with all other behaviour identical.

Verification
REQ-031 SHALL cover: requester 2 only, a=0x3F800000, b=0x40000000, FPU_CMPLT, resp_ready=1 -> next cycle resp_valid=1, resp_id=2, resp_result=1.
REQ-032 SHALL cover: a=0x80000000, b=0x00000000, FPU_CMPEQ -> resp_result=1; a=0x7FC00000, b=0x3F800000, FPU_CMPLE -> resp_result=0.
REQ-033 SHALL cover: all 4 requesters continuously valid, resp_ready=1 from reset -> grant sequence 0,1,2,3,0 on consecutive cycles, one resp_valid per cycle.
REQ-034 SHALL cover: resp_ready=0 for 3 cycles while RESP with requesters 1 and 3 valid -> resp fields stable, req_ready=0 each cycle; after resp_ready rises, requester 1 is granted first.
REQ-035 SHALL cover: rst pulsed while RESP holds an undelivered result -> resp_valid=0 immediately, and requester 0 wins the next arbitration.
REQ-036 SHALL cover: with FP_CMP_ARB_STATS_EN defined, 2 requesters valid for 4 cycles with resp_ready=1 -> stall_count=4.
